bit_level_checker: RTL and testbench



---
 rtl/bit_level_checker_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/bit_level_checker.sv | 121 ++++++++++++
 tb/tb_bit_level_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bit_level_checker_pkg.sv
// Shared definitions for the single-bit level checker: FSM state encodings,
// default timing parameters and the phase-counter width helper.
package bit_level_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam int unsigned DEF_SETTLE = 10;
    localparam int unsigned DEF_WINDOW = 16;
    localparam int unsigned DEF_CNT_W  = 8;

    // Phase counter width: wide enough for the longer of the two phases.
    function automatic int unsigned phase_width(input int unsigned settle,
                                                input int unsigned window);
        int unsigned longest;
        longest = (settle > window) ? settle : window;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports: clk (clock), rstn (async active-low reset), d (async input),
//        q (synchronised output, reset value 0).
module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a cycle to resolve.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bit_level_checker.sv
// Receiver/checker for a single-bit source. A start request synchronises the
// bit, waits SETTLE cycles, then counts WINDOW cycles where the bit differs
// from EXPECTED and reports pass/fail with a saturating error count.
// Ports: clk, rstn (async active-low), start (request, IDLE only),
//        din (async bit under test), busy, done (1-cycle pulse),
//        pass (zero mismatches in last check), err_cnt (saturating count).
module bit_level_checker
    import bit_level_checker_pkg::*;
#(
    parameter logic        EXPECTED = 1'b1,
    parameter int unsigned SETTLE   = DEF_SETTLE,
    parameter int unsigned WINDOW   = DEF_WINDOW,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             din,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned       PH_W        = phase_width(SETTLE, WINDOW);
    localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE - 1);
    localparam logic [PH_W-1:0]   WINDOW_LAST = PH_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  ERR_MAX     = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_d;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_d;
    logic              busy_d;
    logic              done_d;
    logic              pass_d;
    logic [CNT_W-1:0]  err_d;
    logic              din_s;

    sync_2ff u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (din),
        .q    (din_s)
    );

    // State, phase counter and all outputs are registered together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            phase   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_d;
            phase   <= phase_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
            err_cnt <= err_d;
        end
    end

    // Next-state and next-output logic; outputs hold unless a phase changes them.
    always_comb begin
        state_d = state;
        phase_d = phase;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        err_d   = err_cnt;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    phase_d = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                end
            end

            ST_SETTLE: begin
                if (phase == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                    phase_d = '0;
                end else begin
                    phase_d = phase + PH_W'(1);
                end
            end

            ST_CHECK: begin
                if ((din_s != EXPECTED) && (err_cnt != ERR_MAX)) begin
                    err_d = err_cnt + CNT_W'(1);
                end
                // Leaving CHECK registers the result so done/pass appear in REPORT.
                if (phase == WINDOW_LAST) begin
                    state_d = ST_REPORT;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    phase_d = phase + PH_W'(1);
                end
            end

            ST_REPORT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_level_checker.sv
// Directed, table-driven bench for bit_level_checker. A default instance and a
// 3-bit-counter instance share the same stimulus.
module tb_bit_level_checker;
    import bit_level_checker_pkg::*;

    localparam int LAT      = DEF_SETTLE + DEF_WINDOW + 1;   // done cycle
    localparam int BUSY_END = DEF_SETTLE + DEF_WINDOW;       // last busy cycle

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       din;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic       busy3, done3, pass3;
    logic [2:0] err3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_level_checker dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
    );

    bit_level_checker #(.CNT_W(3)) dut_sat (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .din     (din),
        .busy    (busy3),
        .done    (done3),
        .pass    (pass3),
        .err_cnt (err3)
    );

    typedef struct {
        string name;
        logic  din_base;    // din level outside the alternate span
        int    alt_lo;      // cycles alt_lo..alt_hi drive ~din_base
        int    alt_hi;
        int    extra_start; // cycle of an extra start pulse (-1 = none)
        int    exp_mid;     // err_cnt seen in cycle 20
        int    exp_mid3;
        logic  exp_pass;
        int    exp_err;
        int    exp_err3;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input string n, input logic b, input int lo, input int hi,
                                input int xs, input int m, input int m3, input logic p,
                                input int e, input int e3);
        vec_t v;
        v.name = n; v.din_base = b; v.alt_lo = lo; v.alt_hi = hi; v.extra_start = xs;
        v.exp_mid = m; v.exp_mid3 = m3; v.exp_pass = p; v.exp_err = e; v.exp_err3 = e3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Start pulse at edge 0; cycle c is the interval between edges c-1 and c.
    task automatic run_vec(input vec_t v);
        din = v.din_base;
        repeat (3) @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            check({v.name, ".busy"}, 32'(busy), 32'((c >= 1) && (c <= BUSY_END)));
            check({v.name, ".done"}, 32'(done), 32'(c == LAT));
            if (c == 1) begin
                check({v.name, ".pass_clr"}, 32'(pass), 32'(0));
                check({v.name, ".err_clr"}, 32'(err_cnt), 32'(0));
            end
            if (c == 20) begin
                check({v.name, ".err_mid"}, 32'(err_cnt), 32'(v.exp_mid));
                check({v.name, ".err3_mid"}, 32'(err3), 32'(v.exp_mid3));
            end
            if (c == LAT || c == 30) begin
                check({v.name, ".pass"}, 32'(pass), 32'(v.exp_pass));
                check({v.name, ".err"}, 32'(err_cnt), 32'(v.exp_err));
                check({v.name, ".pass3"}, 32'(pass3), 32'(v.exp_pass));
                check({v.name, ".err3"}, 32'(err3), 32'(v.exp_err3));
                check({v.name, ".done3"}, 32'(done3), 32'(c == LAT));
            end
            start = (c == v.extra_start);
            din   = ((c >= v.alt_lo) && (c <= v.alt_hi)) ? ~v.din_base : v.din_base;
        end
        start = 1'b0;
    endtask

    initial begin
        int done_seen;

        vecs[0] = mk("const1",     1'b1,  1,  0, -1, 0, 0, 1'b1,  0, 0);
        vecs[1] = mk("const0",     1'b0,  1,  0, -1, 9, 7, 1'b0, 16, 7);
        vecs[2] = mk("glitch3",    1'b1, 12, 14, -1, 3, 3, 1'b0,  3, 3);
        vecs[3] = mk("settle0",    1'b1,  1,  7, -1, 0, 0, 1'b1,  0, 0);
        vecs[4] = mk("restart5",   1'b1,  1,  0,  5, 0, 0, 1'b1,  0, 0);
        vecs[5] = mk("win_first",  1'b1,  8,  9, -1, 1, 1, 1'b0,  1, 1);
        vecs[6] = mk("win_last",   1'b1, 24, 40, -1, 0, 0, 1'b0,  1, 1);

        rstn  = 1'b0;
        start = 1'b0;
        din   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'(0));
        check("rst.done", 32'(done), 32'(0));
        check("rst.pass", 32'(pass), 32'(0));
        check("rst.err",  32'(err_cnt), 32'(0));
        check("rst.err3", 32'(err3), 32'(0));
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // start held high: re-accepted on the first IDLE cycle after REPORT.
        din = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 58; c++) begin
            @(negedge clk);
            check("hold.done", 32'(done), 32'((c == LAT) || (c == 2 * LAT + 1)));
            check("hold.busy", 32'(busy),
                  32'(((c >= 1) && (c <= BUSY_END)) || ((c >= LAT + 2) && (c <= LAT + 1 + BUSY_END))));
            if (c == 55) begin
                start = 1'b0;
                check("hold.pass", 32'(pass), 32'(1));
            end
        end

        // Reset mid-check aborts with no done pulse.
        din = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort.err_before", 32'(err_cnt), 32'(4));
        check("abort.busy_before", 32'(busy), 32'(1));
        rstn = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'(0));
        check("abort.pass", 32'(pass), 32'(0));
        check("abort.err",  32'(err_cnt), 32'(0));
        check("abort.err3", 32'(err3), 32'(0));
        check("abort.done", 32'(done), 32'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort.no_done", 32'(done_seen), 32'(0));

        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
